srl_bus_var: RTL

Multi-channel, runtime-programmable delay line with per-sample valid tracking and clock enable. Each of BUS_WIDTH lanes shares one shift chain of MAX_DELAY stages; a registered tap select picks the active delay. It replaces fixed-delay bus shift registers wherever the delay has to change at run time, for example for channel alignment after calibration.

---
 rtl/srl_bus_var.sv | 137 +++++++++++++
 1 files changed

// File: rtl/srl_bus_var.sv
// srl_bus_var: multi-lane delay line with a run-time selectable tap.
// All lanes share one chain of MAX_DELAY stages plus a parallel valid chain.
// The active delay d is a register loaded from delay_sel (clamped to MAX_DELAY);
// d = 0 is a combinational bypass. A fill counter drives busy until the chain
// holds d samples captured since the last reset or load.
// Optional feature macro: SRL_BUS_VAR_OUT_REG_EN adds a register after the tap
// mux (latency d+1, bypass becomes a 1-cycle registered path).
module srl_bus_var #(
    parameter int BUS_WIDTH     = 8,
    parameter int MAX_DELAY     = 16,
    parameter int DEFAULT_DELAY = 1,
    parameter int DELAY_W       = $clog2(MAX_DELAY + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 delay_load,
    input  logic [DELAY_W-1:0]   delay_sel,
    input  logic [BUS_WIDTH-1:0] data_input,
    input  logic                 valid_input,
    output logic [BUS_WIDTH-1:0] data_output,
    output logic                 valid_output,
    output logic                 busy
);

`ifdef SRL_BUS_VAR_OUT_REG_EN
    // The output register adds one stage, so the counter must reach MAX_DELAY+1
    // for busy to drop at the largest delay.
    localparam int FC_MAX = MAX_DELAY + 1;
`else
    localparam int FC_MAX = MAX_DELAY;
`endif
    localparam int FC_W = $clog2(FC_MAX + 1);

    if (MAX_DELAY < 1) begin : g_bad_max
        $error("srl_bus_var: MAX_DELAY must be >= 1");
    end
    if (DEFAULT_DELAY < 1 || DEFAULT_DELAY > MAX_DELAY) begin : g_bad_default
        $error("srl_bus_var: DEFAULT_DELAY must be in 1..MAX_DELAY");
    end

    logic [BUS_WIDTH-1:0] s [MAX_DELAY];
    logic [MAX_DELAY-1:0] v;
    logic [DELAY_W-1:0]   d;
    logic [FC_W-1:0]      fc;
    logic [DELAY_W-1:0]   sel_clamped;
    logic [BUS_WIDTH-1:0] tap_data;
    logic                 tap_valid;

    assign sel_clamped = (delay_sel > DELAY_W'(MAX_DELAY)) ? DELAY_W'(MAX_DELAY) : delay_sel;

    // Data chain: shifts on every enabled edge, untouched by loads.
    // NOTE: the data stages are reset (not just the valid bits) because the
    // delayed output must read 0 after reset, not leftover samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MAX_DELAY; i++) s[i] <= '0;
        end else if (en) begin
            s[0] <= data_input;
            for (int i = 1; i < MAX_DELAY; i++) s[i] <= s[i-1];
        end
    end

    // Valid chain: shifts with the data, wiped on a load so stale samples never
    // look valid; a sample captured in the load cycle survives as the first one.
    // NOTE: sequential state uses non-blocking assignments so every stage
    // samples the pre-edge value of its neighbour.
    always_ff @(posedge clk) begin
        if (rst) begin
            v <= '0;
        end else if (delay_load) begin
            v    <= '0;
            v[0] <= en & valid_input;
        end else if (en) begin
            v[0] <= valid_input;
            for (int i = 1; i < MAX_DELAY; i++) v[i] <= v[i-1];
        end
    end

    // Active delay and saturating fill counter; a load restarts the fill.
    always_ff @(posedge clk) begin
        if (rst) begin
            d  <= DELAY_W'(DEFAULT_DELAY);
            fc <= '0;
        end else if (delay_load) begin
            d  <= sel_clamped;
            fc <= en ? FC_W'(1) : '0;
        end else if (en && fc != FC_W'(FC_MAX)) begin
            fc <= fc + FC_W'(1);
        end
    end

    // Tap mux: stage d-1 for d >= 1, live input for d = 0.
    // NOTE: defaults are assigned first so no path through this block leaves
    // an output unassigned, which would infer a latch.
    always_comb begin
        tap_data  = '0;
        tap_valid = 1'b0;
        for (int i = 0; i < MAX_DELAY; i++) begin
            if (d == DELAY_W'(i + 1)) begin
                tap_data  = s[i];
                tap_valid = v[i];
            end
        end
        if (d == '0) begin
            tap_data  = data_input;
            tap_valid = valid_input;
        end
    end

`ifdef SRL_BUS_VAR_OUT_REG_EN
    logic [BUS_WIDTH-1:0] out_data;
    logic                 out_valid;

    // Output register: glitch-free outputs; valid is dropped on a load so the
    // old delay's last sample cannot leak into the new fill window.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            if (en) out_data <= tap_data;
            if (delay_load) out_valid <= 1'b0;
            else if (en)    out_valid <= tap_valid;
        end
    end

    assign data_output  = out_data;
    assign valid_output = out_valid;
    assign busy         = int'(fc) < (int'(d) + 1);
`else
    assign data_output  = tap_data;
    assign valid_output = tap_valid;
    assign busy         = int'(fc) < int'(d);
`endif

endmodule
